switch_ingress_port: RTL and testbench
======================================

// Module: switch_ingress_port
// PURPOSE
// - Ingress stage of one 4-port switch input port; sits directly behind the port interface (valid_ip/data_ip/suspend_ip).
// - Buffers incoming 16-bit packets {data[7:0], source[3:0], target[3:0]} in a FIFO.
// - Back-pressures the driver via suspend_ip.
// - Presents the head packet to the output ports selected by the target bitmap (single, multicast, broadcast).
// - Pops the head only after every targeted output has granted it.
// PARAMETERS
// - DEPTH    4  FIFO entries; power of 2, >= 2
// - PORT_ID  0  this port's index 0..3; informational, used only in stats/debug
// PORTS
// - clk         in   1      switch clock
// - reset       in   1      synchronous, active-low reset
// - valid_ip    in   1      one-cycle packet strobe from port interface
// - data_ip     in   16     {data[15:8], source[7:4], target[3:0]}
// - suspend_ip  out  1      1 = driver must hold off
// - req_o       out  4      per-output request; bit i = head targets port i and not yet served
// - data_o      out  16     head packet, valid while any req_o bit is high
// - gnt_i       in   4      per-output one-cycle grant for the current head
// - drop_o      out  1      one-cycle pulse: packet discarded (target==0 or FIFO full)
// - level_o     out  $clog2(DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
// - Interface timing: one clock; reset is synchronous and active-low.
//   - All state updates on posedge clk.
//   - reset==0 at a posedge: FIFO flushed, pointers/level=0, pend=0.
//   - Outputs during/after reset: suspend_ip=0, req_o=0, data_o=0, drop_o=0, level_o=0.
//   - Reset mid-packet discards all buffered and in-service packets; no partial grant state survives.
// - Write: valid_ip sampled at posedge.
//   - target==0: not written, drop_o=1 next cycle.
//   - level==DEPTH and no pop this cycle: not written, drop_o=1.
//   - Otherwise: written at wr_ptr, wr_ptr wraps modulo DEPTH.
// - suspend_ip = (level_o >= DEPTH-1), decoded from registered level.
//   - Driver samples it at negedge, so the packet launched just before assertion always fits.
// - Head FSM:
//   - EMPTY: req_o=0; when level becomes nonzero, load head, pend<=head.target, go SERVE.
//   - SERVE: req_o=pend, data_o=head.
//     - Each cycle: pend <= pend & ~gnt_i.
//     - gnt_i bits with pend bit 0 are ignored.
//     - When (pend & ~gnt_i)==0: pop, rd_ptr++.
//     - If level after pop > 0: load next head with pend<=its target the same edge (back-to-back, no bubble); else go EMPTY.
// - Latency: packet written at edge N into empty FIFO -> req_o valid from edge N+1.
//   - Minimum head residency 1 cycle (all grants in first cycle).
// - Simultaneous push+pop: level unchanged.
//   - Push accepted when full if a pop occurs the same edge.
// - Multicast/broadcast: grants may arrive in any order over any cycles; data_o stable until pop.
// - level_o arithmetic: +1 push, -1 pop, width $clog2(DEPTH)+1; never exceeds DEPTH, never underflows.
// CONFIGURATION
// - Macro SWITCH_INGRESS_STATS_EN.
// - Defined: adds outputs pkt_cnt_o[15:0] (accepted packets) and drop_cnt_o[15:0] (drop_o pulses).
//   - Both saturate at 16'hFFFF and clear on reset.
// - Undefined: these ports and counters do not exist; all other behaviour identical.
// TESTING
// - Single: reset; valid_ip with data_ip=16'hA512 -> next cycle req_o=4'b0010, data_o=16'hA512; gnt_i=4'b0010 -> req_o=0, level_o=0.
// - Broadcast: target=4'hF; grants 0001,0100,1000,0010 on separate cycles -> req_o shrinks 1111->1110->1010->0010->0000; pop only after the 4th.
// - Full/suspend, DEPTH=4, no grants: 3 packets -> suspend_ip=1 at level 3; 4th accepted (level 4); 5th -> drop_o=1, level stays 4.
// - Target 0: data_ip=16'h3340 -> drop_o=1, level_o unchanged, req_o unchanged.
// - Back-to-back: two packets queued, full grant on head -> next edge data_o=2nd packet, req_o=its target, no idle cycle.
// - Reset mid-multicast: target 4'h5 with gnt 0001 done -> reset low 1 cycle -> req_o=0, level_o=0, suspend_ip=0.

Source files
------------

// File: rtl/switch_ingress_port.sv
// switch_ingress_port
//   Ingress stage for one input of a 4-port switch. Incoming packets
//   {data[15:8], source[7:4], target[3:0]} are buffered in a DEPTH-entry
//   FIFO. The head packet is offered to every output named in its target
//   bitmap. The head is popped once all of those outputs have granted it.
//
// Parameters
//   DEPTH    FIFO entries (power of 2, >= 2)
//   PORT_ID  index of this port (0..3); informational only
//
// Ports
//   clk         switch clock
//   reset       synchronous, active-low reset
//   valid_ip    one-cycle packet strobe from the port interface
//   data_ip     incoming packet
//   suspend_ip  1 = driver must hold off (level >= DEPTH-1)
//   req_o       per-output request for the head packet (unserved targets)
//   data_o      head packet, valid while any req_o bit is high
//   gnt_i       per-output one-cycle grant for the current head
//   drop_o      one-cycle pulse: packet discarded (target 0 or FIFO full)
//   level_o     current FIFO occupancy
//
// Optional feature: define SWITCH_INGRESS_STATS_EN to add pkt_cnt_o
// (accepted packets) and drop_cnt_o (drop_o pulses), both saturating.

module switch_ingress_port #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned PORT_ID = 0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     valid_ip,
   input  logic [15:0]              data_ip,
   output logic                     suspend_ip,
   output logic [3:0]               req_o,
   output logic [15:0]              data_o,
   input  logic [3:0]               gnt_i,
   output logic                     drop_o,
   output logic [$clog2(DEPTH):0]   level_o
`ifdef SWITCH_INGRESS_STATS_EN
   ,
   output logic [15:0]              pkt_cnt_o,
   output logic [15:0]              drop_cnt_o
`endif
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   if (PORT_ID > 3 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_check
      $error("switch_ingress_port: PORT_ID must be 0..3 and DEPTH a power of 2 >= 2");
   end

   typedef enum logic {
      S_EMPTY,
      S_SERVE
   } state_t;

   state_t          state_q, state_d;
   logic [15:0]     mem [DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]   level_q, level_d;
   logic [3:0]      pend_q, pend_d, pend_left;
   logic [15:0]     head_q, head_d;
   logic            drop_q, drop_d;
   logic            push, pop;

   always_comb begin
      pend_left = pend_q & ~gnt_i;
      pop       = (state_q == S_SERVE) && (pend_left == '0);
      // A full FIFO still accepts a packet on the edge that pops the head.
      push      = valid_ip && (data_ip[3:0] != '0) &&
                  ((level_q != LW'(DEPTH)) || pop);
      drop_d    = valid_ip && !push;
      level_d   = level_q + LW'(push) - LW'(pop);

      state_d = state_q;
      pend_d  = pend_q;
      head_d  = head_q;
      case (state_q)
         S_EMPTY: begin
            if (level_q != '0) begin
               state_d = S_SERVE;
               head_d  = mem[rd_ptr_q];
               pend_d  = mem[rd_ptr_q][3:0];
            end
         end
         S_SERVE: begin
            if (!pop) begin
               pend_d = pend_left;
            end else if (level_d == '0) begin
               state_d = S_EMPTY;
               pend_d  = '0;
            end else begin
               // Back-to-back reload. With only the head buffered, the
               // successor is the packet being written on this same edge,
               // so it is taken straight from data_ip.
               head_d = (level_q == LW'(1)) ? data_ip : mem[rd_ptr_q + AW'(1)];
               pend_d = head_d[3:0];
            end
         end
         default: begin
            state_d = S_EMPTY;
            pend_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset && push) begin
         mem[wr_ptr_q] <= data_ip;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= S_EMPTY;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         pend_q   <= '0;
         head_q   <= '0;
         drop_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_q + AW'(push);
         rd_ptr_q <= rd_ptr_q + AW'(pop);
         level_q  <= level_d;
         pend_q   <= pend_d;
         head_q   <= head_d;
         drop_q   <= drop_d;
      end
   end

   assign req_o      = (state_q == S_SERVE) ? pend_q : '0;
   assign data_o     = (state_q == S_SERVE) ? head_q : '0;
   assign suspend_ip = (level_q >= LW'(DEPTH - 1));
   assign drop_o     = drop_q;
   assign level_o    = level_q;

`ifdef SWITCH_INGRESS_STATS_EN
   logic [15:0] pkt_cnt_q, drop_cnt_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         pkt_cnt_q  <= '0;
         drop_cnt_q <= '0;
      end else begin
         if (push && (pkt_cnt_q != '1)) begin
            pkt_cnt_q <= pkt_cnt_q + 16'd1;
         end
         if (drop_q && (drop_cnt_q != '1)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
         end
      end
   end

   assign pkt_cnt_o  = pkt_cnt_q;
   assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_switch_ingress_port.sv
// tb_switch_ingress_port
//   Directed bench for switch_ingress_port (DEPTH=4). A queue-based model
//   of the ingress port is compared with the DUT outputs at every negedge;
//   hand-computed literal expectations pin the key scenarios.

module tb_switch_ingress_port;

   localparam int DEPTH = 4;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk;
   logic          reset;
   logic          valid_ip;
   logic [15:0]   data_ip;
   logic          suspend_ip;
   logic [3:0]    req_o;
   logic [15:0]   data_o;
   logic [3:0]    gnt_i;
   logic          drop_o;
   logic [LW-1:0] level_o;
`ifdef SWITCH_INGRESS_STATS_EN
   logic [15:0]   pkt_cnt_o;
   logic [15:0]   drop_cnt_o;
`endif

   switch_ingress_port #(
      .DEPTH   (DEPTH),
      .PORT_ID (1)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .valid_ip   (valid_ip),
      .data_ip    (data_ip),
      .suspend_ip (suspend_ip),
      .req_o      (req_o),
      .data_o     (data_o),
      .gnt_i      (gnt_i),
      .drop_o     (drop_o),
      .level_o    (level_o)
`ifdef SWITCH_INGRESS_STATS_EN
      ,
      .pkt_cnt_o  (pkt_cnt_o),
      .drop_cnt_o (drop_cnt_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // q holds every buffered packet, oldest first. A head is "presented"
   // (m_hh) from the edge after it became the oldest entry of a previously
   // empty queue, or immediately when it succeeds a popped head.
   logic [15:0] q[$];
   logic        m_hh   = 1'b0;
   logic [3:0]  m_pend = '0;
   logic        m_drop = 1'b0;

   initial begin
      forever begin
         @(posedge clk);
         if (!reset) begin
            q.delete();
            m_hh   = 1'b0;
            m_pend = '0;
            m_drop = 1'b0;
         end else begin
            logic pop, push;
            int   sz;
            sz   = q.size();
            pop  = m_hh && ((m_pend & ~gnt_i) == 4'h0);
            push = valid_ip && (data_ip[3:0] != 4'h0) && (sz < DEPTH || pop);
            m_drop = valid_ip && !push;
            if (pop)  void'(q.pop_front());
            if (push) q.push_back(data_ip);
            if (m_hh && !pop) begin
               m_pend = m_pend & ~gnt_i;
            end else if (m_hh && pop) begin
               m_hh   = (q.size() > 0);
               m_pend = m_hh ? q[0][3:0] : 4'h0;
            end else if (sz > 0) begin
               m_hh   = 1'b1;
               m_pend = q[0][3:0];
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      @(posedge clk);
      forever begin
         logic [3:0] er;
         @(negedge clk);
         er = m_hh ? m_pend : 4'h0;
         chk("model_req",     16'(req_o),      16'(er));
         chk("model_level",   16'(level_o),    16'(q.size()));
         chk("model_suspend", 16'(suspend_ip), 16'(q.size() >= DEPTH - 1));
         chk("model_drop",    16'(drop_o),     16'(m_drop));
         if (er != 4'h0) chk("model_data", data_o, q[0]);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic cyc(input logic v, input logic [15:0] d, input logic [3:0] g);
      valid_ip = v;
      data_ip  = d;
      gnt_i    = g;
      @(posedge clk);
      #1;
      valid_ip = 1'b0;
      data_ip  = '0;
      gnt_i    = '0;
   endtask

   logic [3:0] bc_gnt [4] = '{4'h1, 4'h5, 4'h8, 4'h2};
   logic [3:0] bc_req [4] = '{4'hE, 4'hA, 4'h2, 4'h0};

   initial begin
      #400000;
      errors++;
      $display("FAIL timeout actual=running required=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      reset    = 1'b0;
      valid_ip = 1'b0;
      data_ip  = '0;
      gnt_i    = '0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_req",     16'(req_o),      16'h0);
      chk("rst_level",   16'(level_o),    16'h0);
      chk("rst_suspend", 16'(suspend_ip), 16'h0);
      chk("rst_drop",    16'(drop_o),     16'h0);
      @(posedge clk);
      #1;
      reset = 1'b1;

      // single target
      cyc(1'b1, 16'hA512, 4'h0);
      @(negedge clk);
      chk("single_wr_req",   16'(req_o),   16'h0);
      chk("single_wr_level", 16'(level_o), 16'd1);
      cyc(1'b0, 16'h0, 4'h0);
      @(negedge clk);
      chk("single_req",  16'(req_o), 16'h2);
      chk("single_data", data_o,     16'hA512);
      cyc(1'b0, 16'h0, 4'h2);
      @(negedge clk);
      chk("single_pop_req",   16'(req_o),   16'h0);
      chk("single_pop_level", 16'(level_o), 16'd0);

      // broadcast, grants scattered; a grant to an already-served port is ignored
      cyc(1'b1, 16'h5C0F, 4'h0);
      cyc(1'b0, 16'h0, 4'h0);
      @(negedge clk);
      chk("bc_req0", 16'(req_o), 16'hF);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 16'h0, bc_gnt[i]);
         @(negedge clk);
         chk("bc_req",   16'(req_o),   16'(bc_req[i]));
         chk("bc_level", 16'(level_o), (i < 3) ? 16'd1 : 16'd0);
         if (i < 3) chk("bc_data", data_o, 16'h5C0F);
      end

      // fill, suspend, overflow drop
      cyc(1'b1, 16'h1101, 4'h0);
      cyc(1'b1, 16'h2202, 4'h0);
      cyc(1'b1, 16'h3304, 4'h0);
      @(negedge clk);
      chk("full_l3_level",   16'(level_o),    16'd3);
      chk("full_l3_suspend", 16'(suspend_ip), 16'h1);
      cyc(1'b1, 16'h4408, 4'h0);
      @(negedge clk);
      chk("full_l4_level", 16'(level_o), 16'd4);
      chk("full_l4_drop",  16'(drop_o),  16'h0);
      cyc(1'b1, 16'h5501, 4'h0);
      @(negedge clk);
      chk("full_ovf_drop",  16'(drop_o),  16'h1);
      chk("full_ovf_level", 16'(level_o), 16'd4);
      // back-to-back reload after full grant
      cyc(1'b0, 16'h0, 4'h1);
      @(negedge clk);
      chk("b2b_data",  data_o,           16'h2202);
      chk("b2b_req",   16'(req_o),       16'h2);
      chk("b2b_level", 16'(level_o),     16'd3);
      cyc(1'b1, 16'h6604, 4'h0);
      // push accepted while full because the head pops on the same edge
      cyc(1'b1, 16'h7708, 4'h2);
      @(negedge clk);
      chk("fullpop_level", 16'(level_o), 16'd4);
      chk("fullpop_drop",  16'(drop_o),  16'h0);
      chk("fullpop_data",  data_o,       16'h3304);
      chk("fullpop_req",   16'(req_o),   16'h4);
      cyc(1'b0, 16'h0, 4'h4);
      @(negedge clk);
      chk("drain_data", data_o,     16'h4408);
      chk("drain_req",  16'(req_o), 16'h8);
      cyc(1'b0, 16'h0, 4'h8);
      cyc(1'b0, 16'h0, 4'h4);
      cyc(1'b0, 16'h0, 4'h8);
      @(negedge clk);
      chk("drain_level", 16'(level_o), 16'd0);
      chk("drain_req0",  16'(req_o),   16'h0);

      // target 0 is dropped without disturbing the head
      cyc(1'b1, 16'h9902, 4'h0);
      cyc(1'b0, 16'h0, 4'h0);
      cyc(1'b1, 16'h3340, 4'h0);
      @(negedge clk);
      chk("t0_drop",  16'(drop_o),  16'h1);
      chk("t0_level", 16'(level_o), 16'd1);
      chk("t0_req",   16'(req_o),   16'h2);
      cyc(1'b0, 16'h0, 4'h2);
      @(negedge clk);
      chk("t0_after_drop",  16'(drop_o),  16'h0);
      chk("t0_after_level", 16'(level_o), 16'd0);

      // last entry popped while a new packet arrives: successor presented at once
      cyc(1'b1, 16'hB101, 4'h0);
      cyc(1'b0, 16'h0, 4'h0);
      cyc(1'b1, 16'hC208, 4'h1);
      @(negedge clk);
      chk("byp_req",   16'(req_o),   16'h8);
      chk("byp_data",  data_o,       16'hC208);
      chk("byp_level", 16'(level_o), 16'd1);
      cyc(1'b0, 16'h0, 4'h8);
      @(negedge clk);
      chk("byp_pop_level", 16'(level_o), 16'd0);

      // reset in the middle of a multicast
      cyc(1'b1, 16'hD605, 4'h0);
      cyc(1'b0, 16'h0, 4'h0);
      cyc(1'b0, 16'h0, 4'h1);
      @(negedge clk);
      chk("mc_req", 16'(req_o), 16'h4);
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      chk("mc_rst_req",     16'(req_o),      16'h0);
      chk("mc_rst_level",   16'(level_o),    16'd0);
      chk("mc_rst_suspend", 16'(suspend_ip), 16'h0);
      cyc(1'b0, 16'h0, 4'h4);
      @(negedge clk);
      chk("mc_post_req",   16'(req_o),   16'h0);
      chk("mc_post_level", 16'(level_o), 16'd0);

      repeat (2) @(posedge clk);
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
